// File: rtl/rotate_scan_ctrl_pkg.sv
// Shared definitions for the rotator frame sequencer: default datapath width and FSM states.
package rotate_scan_ctrl_pkg;

   localparam int unsigned SCAN_W = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } scan_state_e;

endpackage

// File: rtl/rot_result_fifo.sv
// Synchronous FIFO holding {dest x, dest y, src x, src y} pairs; head is visible combinationally.
module rot_result_fifo #(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic          pop_i,
   output logic [DW-1:0] data_o,
   output logic [CW-1:0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/rotate_scan_ctrl.sv
// Frame sequencer: row-major scan issued to the rotator under FIFO credit, results paired
// with their destination coordinates and streamed out on valid/ready.
module rotate_scan_ctrl
   import rotate_scan_ctrl_pkg::*;
#(
   parameter int unsigned W          = SCAN_W,
   parameter int unsigned ROT_LAT    = 4,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic         ACLK,
   input  logic         ARESET,
   input  logic         START,
   input  logic [W-1:0] ANGLE_IN,
   input  logic [W-1:0] XMAX,
   input  logic [W-1:0] YMAX,
   output logic         BUSY,
   output logic         DONE,
   output logic         ROT_ENB,
   output logic [W-1:0] ROT_X,
   output logic [W-1:0] ROT_Y,
   output logic [W-1:0] ROT_ANGLE,
   input  logic [W-1:0] ROT_XO,
   input  logic [W-1:0] ROT_YO,
   input  logic         ROT_VALID,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [W-1:0] OUT_DX,
   output logic [W-1:0] OUT_DY,
   output logic [W-1:0] OUT_SX,
   output logic [W-1:0] OUT_SY
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned DW = 4 * W;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   scan_state_e   state_q;
   logic          busy_q;
   logic          done_q;
   logic          enb_q;
   logic [W-1:0]  x_q;
   logic [W-1:0]  y_q;
   logic [W-1:0]  angle_q;
   logic [W-1:0]  xmax_q;
   logic [W-1:0]  ymax_q;
   logic [CW-1:0] in_flight_q;
   logic [CW-1:0] in_flight_d;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_d;
   logic          credit_ok;

   logic [ROT_LAT-1:0] tag_v_q;
   logic [W-1:0]       tag_x_q [ROT_LAT];
   logic [W-1:0]       tag_y_q [ROT_LAT];

   logic          ret;
   logic          pop;
   logic [DW-1:0] fifo_head;

   assign ret = ROT_VALID && tag_v_q[ROT_LAT-1];
   assign pop = OUT_VALID && OUT_READY;

   // ROT_ENB is registered, so credit for next cycle's issue is judged on the occupancy
   // that will exist after this cycle's issue, return and pop have all taken effect.
   always_comb begin
      in_flight_d = in_flight_q + CW'(enb_q) - CW'(ret);
      count_d     = fifo_count + CW'(ret) - CW'(pop);
      credit_ok   = ({1'b0, in_flight_d} + {1'b0, count_d}) < DEPTH_C;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         in_flight_q <= '0;
         tag_v_q     <= '0;
      end else begin
         in_flight_q <= in_flight_d;
         tag_v_q[0]  <= enb_q;
         for (int unsigned i = 1; i < ROT_LAT; i++) begin
            tag_v_q[i] <= tag_v_q[i-1];
         end
      end
   end

   always_ff @(posedge ACLK) begin
      tag_x_q[0] <= x_q;
      tag_y_q[0] <= y_q;
      for (int unsigned i = 1; i < ROT_LAT; i++) begin
         tag_x_q[i] <= tag_x_q[i-1];
         tag_y_q[i] <= tag_y_q[i-1];
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         enb_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         angle_q <= '0;
         xmax_q  <= '0;
         ymax_q  <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (START) begin
                  angle_q <= ANGLE_IN;
                  xmax_q  <= XMAX;
                  ymax_q  <= YMAX;
                  x_q     <= '0;
                  y_q     <= '0;
                  busy_q  <= 1'b1;
                  enb_q   <= credit_ok;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (enb_q && (x_q == xmax_q) && (y_q == ymax_q)) begin
                  enb_q   <= 1'b0;
                  state_q <= S_DRAIN;
               end else begin
                  enb_q <= credit_ok;
                  if (enb_q) begin
                     if (x_q == xmax_q) begin
                        x_q <= '0;
                        y_q <= y_q + 1'b1;
                     end else begin
                        x_q <= x_q + 1'b1;
                     end
                  end
               end
            end
            S_DRAIN: begin
               if ((in_flight_q == '0) && (fifo_count == '0)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   rot_result_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk_i   (ACLK),
      .rst_i   (ARESET),
      .push_i  (ret),
      .data_i  ({tag_x_q[ROT_LAT-1], tag_y_q[ROT_LAT-1], ROT_XO, ROT_YO}),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .count_o (fifo_count)
   );

   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign ROT_ENB   = enb_q;
   assign ROT_X     = x_q;
   assign ROT_Y     = y_q;
   assign ROT_ANGLE = angle_q;
   assign OUT_VALID = (fifo_count != '0);
   assign OUT_DX    = fifo_head[4*W-1:3*W];
   assign OUT_DY    = fifo_head[3*W-1:2*W];
   assign OUT_SX    = fifo_head[2*W-1:W];
   assign OUT_SY    = fifo_head[W-1:0];

endmodule

// File: tb/tb_rotate_scan_ctrl.sv
// Bench for rotate_scan_ctrl: fixed-latency 90-degree rotator model, expected pair queue
// built from the row-major scan rule, and a per-cycle compare process.
module tb_rotate_scan_ctrl;

   localparam int W     = 8;
   localparam int LAT   = 4;
   localparam int DEPTH = 8;

   logic         ACLK = 1'b0;
   logic         ARESET = 1'b1;
   logic         START = 1'b0;
   logic [W-1:0] ANGLE_IN = '0;
   logic [W-1:0] XMAX = '0;
   logic [W-1:0] YMAX = '0;
   logic         BUSY, DONE, ROT_ENB, ROT_VALID, OUT_VALID;
   logic         OUT_READY = 1'b1;
   logic [W-1:0] ROT_X, ROT_Y, ROT_ANGLE, ROT_XO, ROT_YO;
   logic [W-1:0] OUT_DX, OUT_DY, OUT_SX, OUT_SY;

   rotate_scan_ctrl #(
      .W          (W),
      .ROT_LAT    (LAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .START     (START),
      .ANGLE_IN  (ANGLE_IN),
      .XMAX      (XMAX),
      .YMAX      (YMAX),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ROT_ENB   (ROT_ENB),
      .ROT_X     (ROT_X),
      .ROT_Y     (ROT_Y),
      .ROT_ANGLE (ROT_ANGLE),
      .ROT_XO    (ROT_XO),
      .ROT_YO    (ROT_YO),
      .ROT_VALID (ROT_VALID),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_DX    (OUT_DX),
      .OUT_DY    (OUT_DY),
      .OUT_SX    (OUT_SX),
      .OUT_SY    (OUT_SY)
   );

   always #5 ACLK = ~ACLK;

   // Rotator: fixed latency, sx = dy, sy = 255 - dx; it keeps running through DUT resets.
   logic [LAT-1:0] rv_q = '0;
   logic [W-1:0]   rx_q [LAT];
   logic [W-1:0]   ry_q [LAT];

   always @(posedge ACLK) begin
      rv_q    <= {rv_q[LAT-2:0], ROT_ENB};
      rx_q[0] <= ROT_Y;
      ry_q[0] <= 8'd255 - ROT_X;
      for (int i = 1; i < LAT; i++) begin
         rx_q[i] <= rx_q[i-1];
         ry_q[i] <= ry_q[i-1];
      end
   end

   assign ROT_VALID = rv_q[LAT-1];
   assign ROT_XO    = rx_q[LAT-1];
   assign ROT_YO    = ry_q[LAT-1];

   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;
   logic [31:0] exp_q [$];
   logic [31:0] got_q [$];
   logic [7:0]  f_angle = '0;
   logic [7:0]  f_xmax = '0;
   int          ix = 0, iy = 0;
   int          issued = 0, accepted = 0, done_cnt = 0, cyc = 0;
   int          first_enb = -1, first_ov = -1;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_out = '0;
   logic [31:0] out_pair;
   logic [31:0] e;

   assign out_pair = {OUT_DX, OUT_DY, OUT_SX, OUT_SY};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge ACLK) begin
      cyc++;
      if (chk_en) begin
         if (ROT_ENB) begin
            chk("enb_busy", 32'(BUSY), 32'd1);
            chk("issue_coord", {16'd0, ROT_X, ROT_Y}, {16'd0, ix[7:0], iy[7:0]});
            if (first_enb < 0) first_enb = cyc;
            issued++;
            chk("credit", 32'(issued - accepted <= DEPTH), 32'd1);
            if (ix == int'(f_xmax)) begin
               ix = 0;
               iy++;
            end else begin
               ix++;
            end
         end
         if (BUSY) chk("angle", 32'(ROT_ANGLE), 32'(f_angle));
         if (prev_stall) begin
            chk("stall_valid", 32'(OUT_VALID), 32'd1);
            chk("stall_data", out_pair, prev_out);
         end
         if (OUT_VALID && first_ov < 0) first_ov = cyc;
         if (OUT_VALID && OUT_READY) begin
            chk("pair_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("pair", out_pair, e);
            end
            got_q.push_back(out_pair);
            accepted++;
         end
         prev_stall = OUT_VALID && !OUT_READY;
         prev_out   = out_pair;
         if (DONE) begin
            done_cnt++;
            chk("done_drained", 32'(exp_q.size()), 32'd0);
            chk("done_busy", 32'(BUSY), 32'd0);
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic cycle();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk_reset();
      chk("rst_busy",  32'(BUSY), 32'd0);
      chk("rst_done",  32'(DONE), 32'd0);
      chk("rst_enb",   32'(ROT_ENB), 32'd0);
      chk("rst_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_x",     32'(ROT_X), 32'd0);
      chk("rst_y",     32'(ROT_Y), 32'd0);
      chk("rst_angle", 32'(ROT_ANGLE), 32'd0);
   endtask

   task automatic start_frame(input logic [7:0] a, input logic [7:0] xm, input logic [7:0] ym);
      cycle();
      START    = 1'b1;
      ANGLE_IN = a;
      XMAX     = xm;
      YMAX     = ym;
      exp_q.delete();
      got_q.delete();
      for (int y = 0; y <= int'(ym); y++) begin
         for (int x = 0; x <= int'(xm); x++) begin
            exp_q.push_back({x[7:0], y[7:0], y[7:0], 8'(255 - x)});
         end
      end
      f_angle   = a;
      f_xmax    = xm;
      ix        = 0;
      iy        = 0;
      issued    = 0;
      accepted  = 0;
      done_cnt  = 0;
      first_enb = -1;
      first_ov  = -1;
      cycle();
      START = 1'b0;
   endtask

   task automatic finish_frame(input int npix, input int rmode, input int budget);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         cycle();
         OUT_READY = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (done_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
      OUT_READY = 1'b1;
      chk("done_seen", 32'(ok), 32'd1);
      repeat (3) cycle();
      chk("done_once",  32'(done_cnt), 32'd1);
      chk("pair_count", 32'(accepted), 32'(npix));
      chk("exp_empty",  32'(exp_q.size()), 32'd0);
      chk("busy_after", 32'(BUSY), 32'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      ARESET = 1'b1;
      repeat (3) cycle();
      ARESET = 1'b0;
      chk_reset();
      chk_en = 1'b1;

      // 4x2 frame, ready held high
      start_frame(8'h40, 8'd3, 8'd1);
      finish_frame(8, 0, 200);
      chk("f1_latency", 32'(first_ov - first_enb), 32'(LAT + 1));
      chk("f1_pair5", got_q[5], {8'd1, 8'd1, 8'd1, 8'd254});
      chk("f1_last",  got_q[7], {8'd3, 8'd1, 8'd1, 8'd252});

      // single-pixel frame
      start_frame(8'h40, 8'd0, 8'd0);
      finish_frame(1, 0, 100);
      chk("f2_pair", got_q[0], 32'h0000_00FF);
      chk("f2_issues", 32'(issued), 32'd1);

      // ignored START mid-frame, then a long output stall
      start_frame(8'h40, 8'd15, 8'd3);
      repeat (3) cycle();
      START    = 1'b1;
      ANGLE_IN = 8'hC0;
      XMAX     = 8'd1;
      YMAX     = 8'd1;
      cycle();
      START = 1'b0;
      repeat (6) cycle();
      OUT_READY = 1'b0;
      repeat (40) cycle();
      chk("stall_enb_off", 32'(ROT_ENB), 32'd0);
      chk("stall_held", 32'(issued - accepted), 32'(DEPTH));
      finish_frame(64, 0, 500);
      chk("f3_last", got_q[63], {8'd15, 8'd3, 8'd3, 8'd240});

      // reset mid-frame, then an immediate new frame
      start_frame(8'h22, 8'd7, 8'd7);
      repeat (12) cycle();
      chk_en = 1'b0;
      ARESET = 1'b1;
      cycle();
      ARESET = 1'b0;
      chk_reset();
      exp_q.delete();
      done_cnt = 0;
      chk_en = 1'b1;
      start_frame(8'h10, 8'd2, 8'd2);
      finish_frame(9, 0, 200);
      chk("f4_first", got_q[0], 32'h0000_00FF);
      chk("f4_last",  got_q[8], {8'd2, 8'd2, 8'd2, 8'd253});

      // full-width row with random backpressure
      start_frame(8'h7F, 8'd255, 8'd7);
      finish_frame(2048, 1, 9000);
      chk("f5_last", got_q[2047], {8'd255, 8'd7, 8'd7, 8'd0});

      // full-height column range
      start_frame(8'h01, 8'd3, 8'd255);
      finish_frame(1024, 0, 2000);
      chk("f6_last", got_q[1023], {8'd3, 8'd255, 8'd255, 8'd252});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
